// File: rtl/bifrost_pkg.sv
// Shared constants for the button front end: channel count and default debounce width.
package bifrost_pkg;

  localparam int unsigned NUM_BUTTONS           = 8;
  localparam int unsigned DEBOUNCE_BITS_DEFAULT = 16;

endpackage

// File: rtl/debounce.sv
// One button channel: 2-flop synchronizer, saturating-free debounce counter and
// debounced level flop, with single-cycle rise/fall pulses aligned to the state edge.
module debounce
  import bifrost_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = DEBOUNCE_BITS_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_n_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  logic                     meta_q, sync_q, state_q, state_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     sync, differ, done;

  assign sync   = ~sync_q;
  assign differ = sync ^ state_q;
  assign done   = differ & (&cnt_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    if (differ) begin
      if (&cnt_q) state_d = sync;
      else        cnt_d   = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      meta_q  <= pin_n_i;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Pulses are combinational so event flops can set on the same edge as the state change.
  assign state_o = state_q;
  assign rise_o  = done & sync;
  assign fall_o  = done & ~sync;

endmodule

// File: rtl/buttons.sv
// Debounced button bank with sticky, maskable-ack press events and a pending flag.
// Optional macro BUTTONS_RELEASE_EN adds sticky release events on a released port.
module buttons
  import bifrost_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = DEBOUNCE_BITS_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  input  logic                   enable,
  output logic [NUM_BUTTONS-1:0] state,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic                   pending,
  input  logic                   ack,
  input  logic [NUM_BUTTONS-1:0] ack_mask
`ifdef BUTTONS_RELEASE_EN
  ,
  output logic [NUM_BUTTONS-1:0] released
`endif
);

  logic [NUM_BUTTONS-1:0] rise_w, fall_w, clr_mask;
  logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
  logic                   pending_q, pending_d;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db (
      .clock   (clock),
      .reset   (reset),
      .pin_n_i (buttons_n[i]),
      .state_o (state[i]),
      .rise_o  (rise_w[i]),
      .fall_o  (fall_w[i])
    );
  end

  // Clear is applied before the set term, so a same-cycle new event wins over ack.
  assign clr_mask  = ack ? ack_mask : '0;
  assign pressed_d = (pressed_q & ~clr_mask) | (rise_w & {NUM_BUTTONS{enable}});

`ifdef BUTTONS_RELEASE_EN
  logic [NUM_BUTTONS-1:0] released_q, released_d;

  assign released_d = (released_q & ~clr_mask) | (fall_w & {NUM_BUTTONS{enable}});
  assign pending_d  = (|pressed_d) | (|released_d);
  assign released   = released_q;

  always_ff @(posedge clock) begin
    if (reset) released_q <= '0;
    else       released_q <= released_d;
  end
`else
  logic unused_fall;

  assign unused_fall = |fall_w;
  assign pending_d   = |pressed_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pressed_q <= '0;
      pending_q <= 1'b0;
    end else begin
      pressed_q <= pressed_d;
      pending_q <= pending_d;
    end
  end

  assign pressed = pressed_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_buttons.sv
// Scoreboard bench for buttons with DEBOUNCE_BITS=4: expectations are queued with a
// target cycle when stimulus is driven and compared on the falling edge of that cycle.
module tb_buttons;

  localparam int unsigned DB  = 4;
  localparam int          LAT = 2 + (1 << DB);
`ifdef BUTTONS_RELEASE_EN
  localparam logic [7:0]  REL = 8'hFF;
`else
  localparam logic [7:0]  REL = 8'h00;
`endif

  logic       clock = 1'b0;
  logic       reset, enable, ack, pending;
  logic [7:0] buttons_n, ack_mask, state, pressed;
`ifdef BUTTONS_RELEASE_EN
  logic [7:0] released;
`endif

  buttons #(.DEBOUNCE_BITS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .buttons_n (buttons_n),
    .enable    (enable),
    .state     (state),
    .pressed   (pressed),
    .pending   (pending),
    .ack       (ack),
    .ack_mask  (ack_mask)
`ifdef BUTTONS_RELEASE_EN
    ,
    .released  (released)
`endif
  );

  typedef struct packed {
    int unsigned cyc;
    logic [7:0]  st;
    logic [7:0]  pr;
    logic [7:0]  rl;
    logic        pe;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  exp_t        mon_e;
  string       mon_t;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // pending is modelled as the OR of the expected event bits.
  task automatic expect_in(input int n, input string tag, input logic [7:0] st,
                           input logic [7:0] pr, input logic [7:0] rl);
    exp_t e;
    e.cyc = cyc + n;
    e.st  = st;
    e.pr  = pr;
    e.rl  = rl;
    e.pe  = (|pr) | (|rl);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      check({mon_t, ".state"},   32'(state),   32'(mon_e.st));
      check({mon_t, ".pressed"}, 32'(pressed), 32'(mon_e.pr));
      check({mon_t, ".pending"}, 32'(pending), 32'(mon_e.pe));
`ifdef BUTTONS_RELEASE_EN
      check({mon_t, ".released"}, 32'(released), 32'(mon_e.rl));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1; ack = 1'b0; ack_mask = 8'h00; buttons_n = 8'hFF;
    step(3);
    expect_in(1, "rst", 8'h00, 8'h00, 8'h00);
    step(2);
    reset = 1'b0;

    // Clean press of bit 3: exact latency.
    buttons_n = 8'hF7;
    for (int i = 1; i < LAT; i++) expect_in(i, "a_wait", 8'h00, 8'h00, 8'h00);
    expect_in(LAT, "a_press", 8'h08, 8'h08, 8'h00);
    step(LAT + 2);

    // Short glitch on bit 5 never reaches state.
    buttons_n = 8'hD7;
    for (int i = 1; i <= 26; i++) expect_in(i, "b_glitch", 8'h08, 8'h08, 8'h00);
    step(10);
    buttons_n = 8'hF7;
    step(16);

    // Build pressed=09, masked ack of bit 3.
    buttons_n = 8'hF6;
    expect_in(LAT - 1, "c_pre", 8'h08, 8'h08, 8'h00);
    expect_in(LAT, "c_press", 8'h09, 8'h09, 8'h00);
    step(LAT + 2);
    ack = 1'b1; ack_mask = 8'h08;
    expect_in(1, "c_ack3", 8'h09, 8'h01, 8'h00);
    step(1);
    ack = 1'b0; ack_mask = 8'h00;
    step(2);

    // Release bit 0, then re-press with ack landing on the rise edge.
    buttons_n = 8'hF7;
    expect_in(LAT, "c_rel0", 8'h08, 8'h01, 8'h01 & REL);
    step(LAT + 2);
    buttons_n = 8'hF6;
    step(LAT - 1);
    ack = 1'b1; ack_mask = 8'h01;
    expect_in(1, "c_setwins", 8'h09, 8'h01, 8'h00);
    step(1);
    ack = 1'b0; ack_mask = 8'h00;
    step(1);
    ack = 1'b1; ack_mask = 8'h01;
    expect_in(1, "c_ack0", 8'h09, 8'h00, 8'h00);
    step(1);
    ack = 1'b0; ack_mask = 8'h00;
    step(1);

    // Capture disabled: state follows, no events.
    enable = 1'b0;
    buttons_n = 8'hF2;
    expect_in(LAT - 1, "d_pre", 8'h09, 8'h00, 8'h00);
    expect_in(LAT, "d_quiet", 8'h0D, 8'h00, 8'h00);
    step(30);
    buttons_n = 8'hF6;
    expect_in(LAT, "d_rel", 8'h09, 8'h00, 8'h00);
    step(LAT + 1);
    enable = 1'b1;

    // Reset in the middle of a bit-6 count; held buttons reappear afterwards.
    buttons_n = 8'hB6;
    step(10);
    reset = 1'b1;
    expect_in(1, "e_reset", 8'h00, 8'h00, 8'h00);
    step(2);
    reset = 1'b0;
    expect_in(LAT - 1, "e_pre", 8'h00, 8'h00, 8'h00);
    expect_in(LAT, "e_held", 8'h49, 8'h49, 8'h00);
    step(LAT + 2);
    ack = 1'b1; ack_mask = 8'hFF;
    expect_in(1, "e_ackall", 8'h49, 8'h00, 8'h00);
    step(1);
    ack = 1'b0; ack_mask = 8'h00;
    step(1);

    // Press and release bit 1, then ack it.
    buttons_n = 8'hB4;
    expect_in(LAT, "f_press", 8'h4B, 8'h02, 8'h00);
    step(LAT + 2);
    buttons_n = 8'hB6;
    expect_in(LAT - 1, "f_pre", 8'h4B, 8'h02, 8'h00);
    expect_in(LAT, "f_rel", 8'h49, 8'h02, 8'h02 & REL);
    step(LAT + 2);
    ack = 1'b1; ack_mask = 8'h02;
    expect_in(1, "f_ack", 8'h49, 8'h00, 8'h00);
    step(1);
    ack = 1'b0; ack_mask = 8'h00;
    step(4);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
